// File: rtl/atm_pkg.sv
// Shared definitions for the ATM keypad capture stage and its transaction controller.
package atm_pkg;

    // Width of the binary amount handed to the controller.
    localparam int ANCHO_MONTO = 32;

    // Special key codes; 0..9 are digits, 4'hC..4'hF carry no meaning.
    localparam logic [3:0] TECLA_ENTER  = 4'hA;
    localparam logic [3:0] TECLA_BORRAR = 4'hB;

    // Capture FSM encoding.
    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        CAPTURA  = 2'd1,
        ENTREGA  = 2'd2
    } estado_t;

    // True when the key code is a decimal digit.
    function automatic logic es_digito(input logic [3:0] tecla);
        return (tecla <= 4'd9);
    endfunction

    // acc*10 + digit, built from shifts so no multiplier is inferred.
    function automatic logic [ANCHO_MONTO-1:0] acumular(
        input logic [ANCHO_MONTO-1:0] acc,
        input logic [3:0]             digito
    );
        return (acc << 3) + (acc << 1) + {{(ANCHO_MONTO-4){1'b0}}, digito};
    endfunction

endpackage

// File: rtl/captura_monto_detector_flanco.sv
// 1-bit rising-edge detector: flags the cycle in which the input is high
// and was low in the previous cycle. Also used on the controller's strobes.
module detector_flanco (
    input  logic clk_i,
    input  logic rst_i,
    input  logic nivel_i,
    output logic flanco_o
);

    logic previo_q;

    // History of the input level, cleared by the synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            previo_q <= 1'b0;
        end else begin
            previo_q <= nivel_i;
        end
    end

    assign flanco_o = nivel_i & ~previo_q;

endmodule

// File: rtl/captura_monto.sv
// Keypad amount capture: turns strobed decimal key codes into a binary
// amount and hands it to the transaction controller with a one-cycle strobe.
module captura_monto
    import atm_pkg::*;
#(
    parameter int MAX_DIGITOS = 9
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   HABILITAR,
    input  logic [3:0]             TECLA,
    input  logic                   TECLA_STB,
    output logic [ANCHO_MONTO-1:0] MONTO,
    output logic                   MONTO_STB,
    output logic [3:0]             CONTEO,
    output logic                   ERROR_DIGITOS
);

    // Nine decimal digits is the most that fits in 32 bits without overflow.
    localparam logic [3:0] MAX_CONTEO = 4'(MAX_DIGITOS);

    estado_t                estado_q, estado_d;
    logic [ANCHO_MONTO-1:0] acc_q, acc_d;
    logic [3:0]             conteo_q, conteo_d;
    logic [ANCHO_MONTO-1:0] monto_q, monto_d;
    logic                   monto_stb_q, monto_stb_d;
    logic                   error_q, error_d;
    logic                   tecla_ok_s;

    // A key is taken only on the rising edge of its strobe.
    detector_flanco u_flanco_tecla (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .nivel_i  (TECLA_STB),
        .flanco_o (tecla_ok_s)
    );

    // State and datapath registers; reset drops any pending strobe.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            estado_q    <= INACTIVO;
            acc_q       <= '0;
            conteo_q    <= 4'd0;
            monto_q     <= '0;
            monto_stb_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            acc_q       <= acc_d;
            conteo_q    <= conteo_d;
            monto_q     <= monto_d;
            monto_stb_q <= monto_stb_d;
            error_q     <= error_d;
        end
    end

    // Next-state and datapath decode; HABILITAR low overrides any key.
    always_comb begin
        estado_d    = estado_q;
        acc_d       = acc_q;
        conteo_d    = conteo_q;
        monto_d     = monto_q;
        monto_stb_d = 1'b0;
        error_d     = 1'b0;

        case (estado_q)
            INACTIVO: begin
                acc_d    = '0;
                conteo_d = 4'd0;
                if (HABILITAR) begin
                    estado_d = CAPTURA;
                end else begin
                    estado_d = INACTIVO;
                end
            end

            CAPTURA: begin
                if (!HABILITAR) begin
                    // Partial amount is discarded; MONTO keeps its last value.
                    estado_d = INACTIVO;
                    acc_d    = '0;
                    conteo_d = 4'd0;
                end else if (tecla_ok_s) begin
                    if (es_digito(TECLA)) begin
                        if (conteo_q < MAX_CONTEO) begin
                            acc_d    = acumular(acc_q, TECLA);
                            conteo_d = conteo_q + 4'd1;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else if (TECLA == TECLA_BORRAR) begin
                        acc_d    = '0;
                        conteo_d = 4'd0;
                    end else if (TECLA == TECLA_ENTER) begin
                        if (conteo_q != 4'd0) begin
                            monto_d     = acc_q;
                            monto_stb_d = 1'b1;
                            estado_d    = ENTREGA;
                        end else begin
                            estado_d = CAPTURA;
                        end
                    end else begin
                        estado_d = CAPTURA;
                    end
                end else begin
                    estado_d = CAPTURA;
                end
            end

            ENTREGA: begin
                // Single cycle; any key edge seen here is dropped.
                acc_d    = '0;
                conteo_d = 4'd0;
                if (HABILITAR) begin
                    estado_d = CAPTURA;
                end else begin
                    estado_d = INACTIVO;
                end
            end

            default: begin
                estado_d = INACTIVO;
                acc_d    = '0;
                conteo_d = 4'd0;
            end
        endcase
    end

    assign MONTO         = monto_q;
    assign MONTO_STB     = monto_stb_q;
    assign CONTEO        = conteo_q;
    assign ERROR_DIGITOS = error_q;

endmodule

// File: tb/tb_captura_monto.sv
// Directed self-checking bench for captura_monto.
`timescale 1ns/1ps
module tb_captura_monto;

    logic        CLK;
    logic        RESET;
    logic        HABILITAR;
    logic [3:0]  TECLA;
    logic        TECLA_STB;
    logic [31:0] MONTO;
    logic        MONTO_STB;
    logic [3:0]  CONTEO;
    logic        ERROR_DIGITOS;

    int checks;
    int errors;

    captura_monto #(.MAX_DIGITOS(9)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .HABILITAR     (HABILITAR),
        .TECLA         (TECLA),
        .TECLA_STB     (TECLA_STB),
        .MONTO         (MONTO),
        .MONTO_STB     (MONTO_STB),
        .CONTEO        (CONTEO),
        .ERROR_DIGITOS (ERROR_DIGITOS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish before 200000ns");
        $fatal(1);
    end

    // Press a key: strobe high for one edge, then low. Returns at the
    // falling edge of the cycle right after the accepting edge.
    task automatic press(input logic [3:0] k);
        @(negedge CLK);
        TECLA     = k;
        TECLA_STB = 1'b1;
        @(negedge CLK);
        TECLA_STB = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; HABILITAR = 1'b0; TECLA = 4'd0; TECLA_STB = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (MONTO !== 32'd0 || MONTO_STB !== 1'b0 || CONTEO !== 4'd0 || ERROR_DIGITOS !== 1'b0) begin
            errors++;
            $display("FAIL reset: MONTO=%0d STB=%b CONTEO=%0d ERR=%b, required 0 0 0 0",
                     MONTO, MONTO_STB, CONTEO, ERROR_DIGITOS);
        end
        RESET = 1'b0;
        HABILITAR = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_monto_basico();
        press(4'd2); press(4'd7); press(4'd2); press(4'd7); press(4'd2); press(4'd7);
        checks++;
        if (CONTEO !== 4'd6) begin
            errors++; $display("FAIL conteo6: got %0d required 6", CONTEO);
        end
        press(4'hA);
        checks++;
        if (MONTO_STB !== 1'b1 || MONTO !== 32'h00042957) begin
            errors++; $display("FAIL enter272727: STB=%b MONTO=%h required 1 00042957", MONTO_STB, MONTO);
        end
        @(negedge CLK);
        checks++;
        if (MONTO_STB !== 1'b0 || CONTEO !== 4'd0 || MONTO !== 32'h00042957) begin
            errors++; $display("FAIL post_enter: STB=%b CONTEO=%0d MONTO=%h required 0 0 00042957",
                               MONTO_STB, CONTEO, MONTO);
        end
    endtask

    task automatic test_desborde();
        int err_seen;
        err_seen = 0;
        for (int i = 0; i < 9; i++) begin
            press(4'd9);
            if (ERROR_DIGITOS === 1'b1) err_seen++;
        end
        checks++;
        if (CONTEO !== 4'd9 || err_seen != 0) begin
            errors++; $display("FAIL nueve_digitos: CONTEO=%0d errpulses=%0d required 9 0", CONTEO, err_seen);
        end
        press(4'd1);
        checks++;
        if (ERROR_DIGITOS !== 1'b1 || CONTEO !== 4'd9) begin
            errors++; $display("FAIL decimo_digito: ERR=%b CONTEO=%0d required 1 9", ERROR_DIGITOS, CONTEO);
        end
        @(negedge CLK);
        checks++;
        if (ERROR_DIGITOS !== 1'b0) begin
            errors++; $display("FAIL error_un_ciclo: ERR=%b required 0", ERROR_DIGITOS);
        end
        press(4'hA);
        checks++;
        if (MONTO_STB !== 1'b1 || MONTO !== 32'd999999999) begin
            errors++; $display("FAIL enter999999999: STB=%b MONTO=%0d required 1 999999999", MONTO_STB, MONTO);
        end
        @(negedge CLK);
    endtask

    task automatic test_borrar();
        press(4'd5); press(4'd5); press(4'hB);
        checks++;
        if (CONTEO !== 4'd0) begin
            errors++; $display("FAIL borrar: CONTEO=%0d required 0", CONTEO);
        end
        press(4'hC);
        checks++;
        if (CONTEO !== 4'd0) begin
            errors++; $display("FAIL tecla_ignorada: CONTEO=%0d required 0", CONTEO);
        end
        press(4'd3); press(4'hA);
        checks++;
        if (MONTO_STB !== 1'b1 || MONTO !== 32'd3) begin
            errors++; $display("FAIL enter3: STB=%b MONTO=%0d required 1 3", MONTO_STB, MONTO);
        end
        @(negedge CLK);
        press(4'hA);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (MONTO_STB !== 1'b0 || MONTO !== 32'd3) begin
                errors++; $display("FAIL enter_vacio: STB=%b MONTO=%0d required 0 3", MONTO_STB, MONTO);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_strobe_sostenido();
        @(negedge CLK);
        TECLA = 4'd4; TECLA_STB = 1'b1;
        repeat (5) @(negedge CLK);
        TECLA_STB = 1'b0;
        checks++;
        if (CONTEO !== 4'd1) begin
            errors++; $display("FAIL strobe_sostenido: CONTEO=%0d required 1", CONTEO);
        end
        HABILITAR = 1'b0;
        @(negedge CLK);
        checks++;
        if (CONTEO !== 4'd0 || MONTO !== 32'd3 || MONTO_STB !== 1'b0) begin
            errors++; $display("FAIL deshabilitar: CONTEO=%0d MONTO=%0d STB=%b required 0 3 0",
                               CONTEO, MONTO, MONTO_STB);
        end
        press(4'd6);
        checks++;
        if (CONTEO !== 4'd0) begin
            errors++; $display("FAIL inactivo_ignora: CONTEO=%0d required 0", CONTEO);
        end
    endtask

    task automatic test_reset_medio();
        HABILITAR = 1'b1;
        @(negedge CLK);
        press(4'd8); press(4'd8);
        checks++;
        if (CONTEO !== 4'd2) begin
            errors++; $display("FAIL conteo88: CONTEO=%0d required 2", CONTEO);
        end
        RESET = 1'b1;
        @(negedge CLK);
        checks++;
        if (CONTEO !== 4'd0 || MONTO !== 32'd0 || MONTO_STB !== 1'b0 || ERROR_DIGITOS !== 1'b0) begin
            errors++; $display("FAIL reset_medio: CONTEO=%0d MONTO=%0d STB=%b ERR=%b required 0 0 0 0",
                               CONTEO, MONTO, MONTO_STB, ERROR_DIGITOS);
        end
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_enter_con_caida();
        press(4'd1);
        checks++;
        if (CONTEO !== 4'd1) begin
            errors++; $display("FAIL conteo1: CONTEO=%0d required 1", CONTEO);
        end
        @(negedge CLK);
        TECLA = 4'hA; TECLA_STB = 1'b1; HABILITAR = 1'b0;
        @(negedge CLK);
        TECLA_STB = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (MONTO_STB !== 1'b0 || MONTO !== 32'd0 || CONTEO !== 4'd0) begin
                errors++; $display("FAIL enter_caida: STB=%b MONTO=%0d CONTEO=%0d required 0 0 0",
                                   MONTO_STB, MONTO, CONTEO);
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_monto_basico();
        test_desborde();
        test_borrar();
        test_strobe_sostenido();
        test_reset_medio();
        test_enter_con_caida();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/captura_monto.md
# captura_monto

Keypad amount-capture stage that sits directly upstream of the ATM transaction controller. It converts a stream of strobed decimal keypad codes into a 32-bit binary amount on `MONTO`, qualified by a one-cycle `MONTO_STB` pulse. The controller consumes `MONTO` and `MONTO_STB` during its transaction phase. Capture is enabled only while the controller asserts `HABILITAR`; digit entry, clear and confirm keys are handled locally.

## Interface
- `MAX_DIGITOS`, default 9: maximum number of digits accepted. Legal range 1..9, which guarantees no 32-bit overflow.
- `CLK` input, 1 bit: single clock. Everything is rising-edge.
- `RESET` input, 1 bit: synchronous, active-high reset.
- `HABILITAR` input, 1 bit: level from the controller, meaning an amount is awaited.
- `TECLA` input, 4 bits: key code. 0–9 are digits; 4'hA is ENTER; 4'hB is BORRAR (clear); 4'hC–4'hF are ignored.
- `TECLA_STB` input, 1 bit: key-valid level. A key is taken only on its 0→1 edge.
- `MONTO` output, 32 bits: confirmed amount, binary.
- `MONTO_STB` output, 1 bit: one-cycle pulse marking a new `MONTO`.
- `CONTEO` output, 4 bits: digits currently accumulated.
- `ERROR_DIGITOS` output, 1 bit: one-cycle pulse when a digit is rejected because the buffer is full.

## Operation
- Key acceptance: a key is accepted in a cycle where `TECLA_STB`=1 and its registered previous value was 0. `TECLA` is sampled in that same cycle. Holding the strobe high never repeats a key.
- FSM states:
  - **INACTIVO**: accumulator = 0, `CONTEO` = 0, all keys ignored. Moves to CAPTURA when `HABILITAR`=1.
  - **CAPTURA**:
    - Digit with `CONTEO` < `MAX_DIGITOS`: acc ← acc·10 + digit, computed as (acc<<3)+(acc<<1)+digit in 32 bits, and `CONTEO`++.
    - Digit with `CONTEO` = `MAX_DIGITOS`: digit dropped, `ERROR_DIGITOS` pulses.
    - BORRAR: acc and `CONTEO` ← 0.
    - ENTER with `CONTEO` > 0: `MONTO` ← acc, go to ENTREGA.
    - ENTER with `CONTEO` = 0: ignored.
  - **ENTREGA**: lasts exactly one cycle. `MONTO_STB` = 1; acc and `CONTEO` are cleared. Returns to CAPTURA, or to INACTIVO if `HABILITAR`=0. This lets the controller request a retry, e.g. after insufficient funds.
- `HABILITAR`=0 in CAPTURA moves the FSM to INACTIVO on the next edge and discards the partial amount.
- Simultaneous events: if `HABILITAR` falls in the same cycle an ENTER is accepted, `HABILITAR` wins, `MONTO` is unchanged and no strobe is produced.
- `MONTO` holds its value until the next confirmed ENTER or `RESET`. It is not cleared on leaving CAPTURA.
- Leading zeros count as digits: "0","0","5" gives `CONTEO`=3 and amount 5.

## Timing
- Reset values: state INACTIVO, `MONTO`=0, `MONTO_STB`=0, `CONTEO`=0, `ERROR_DIGITOS`=0, strobe history register=0.
- Reset asserted mid-capture clears everything on that edge and drops any pending strobe.
- A key accepted at edge n is reflected in `CONTEO` and the accumulator after edge n.
- ENTER accepted at edge n: `MONTO` is valid and `MONTO_STB`=1 during cycle n+1; `MONTO_STB`=0 from n+2.
- `ERROR_DIGITOS` is high for exactly the one cycle after the rejected key.
- A strobe edge arriving while the FSM is in ENTREGA is consumed and ignored.
- Minimum key spacing is 2 cycles (strobe high then low). No other handshake exists with the controller.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package `atm_pkg` holds:
  - key code constants: `TECLA_ENTER`=4'hA, `TECLA_BORRAR`=4'hB;
  - FSM state encoding (INACTIVO, CAPTURA, ENTREGA);
  - the 32-bit amount width constant, shared with the controller.
- One sub-module, `detector_flanco`: a 1-bit rising-edge detector with synchronous reset, reused for the controller's own strobes.
- Everything else stays in the top module.

## Test plan
1. Reset, `HABILITAR`=1, keys 2,7,2,7,2,7 then ENTER → `MONTO`=272727 (32'h00042957), `MONTO_STB` high exactly one cycle, one cycle after ENTER; `CONTEO` back to 0.
2. Keys 9 ×9, then key 1, then ENTER → `ERROR_DIGITOS` pulses once on the tenth digit; `MONTO`=999999999; `CONTEO` peaks at 9.
3. Keys 5,5, BORRAR, 3, ENTER → `MONTO`=3. Then ENTER with no digits → no `MONTO_STB`, `MONTO` stays 3.
4. Hold `TECLA_STB` high for 5 cycles with `TECLA`=4 → `CONTEO`=1 only. Then `HABILITAR`=0 → `CONTEO`=0 next cycle, `MONTO` unchanged.
5. `RESET`=1 after keys 8,8 mid-entry → all outputs return to 0 on that edge. Also: ENTER in the same cycle `HABILITAR` falls → no strobe produced.
